// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port (CPU / HOST) arbiter and access sequencer for a
//            single-port, word-addressed data memory with 1-cycle synchronous
//            read latency. One access every 3 cycles: IDLE -> ISSUE -> CAPTURE.
// Config   : DMEM_ARB_RR_EN defined   -> round-robin tie-break on last owner
//            DMEM_ARB_RR_EN undefined -> fixed priority, CPU wins ties
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              host_gnt_o,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  localparam logic c_OWN_CPU  = 1'b0;
  localparam logic c_OWN_HOST = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                we_q, we_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic                host_gnt_q, host_gnt_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;

  logic                w_tie_host;
  logic                w_pick_host;

  // On a simultaneous request: HOST wins only if CPU owned the last access
`ifdef DMEM_ARB_RR_EN
  assign w_tie_host = (last_owner_q == c_OWN_CPU);
`else
  assign w_tie_host = 1'b0;
`endif

  assign w_pick_host = host_req_i & (~cpu_req_i | w_tie_host);

  // Next-state decode; every output is computed here and registered below
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cpu_gnt_d    = 1'b0;
    host_gnt_d   = 1'b0;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req_i || host_req_i) begin
          owner_d     = w_pick_host ? c_OWN_HOST : c_OWN_CPU;
          we_d        = w_pick_host ? host_we_i : cpu_we_i;
          mem_addr_d  = w_pick_host ? host_addr_i : cpu_addr_i;
          mem_wdata_d = w_pick_host ? host_wdata_i : cpu_wdata_i;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          cpu_gnt_d   = ~w_pick_host;
          host_gnt_d  = w_pick_host;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Memory has the command now; address/data simply hold
        last_owner_d = owner_q;
        state_d      = S_CAPTURE;
      end
      S_CAPTURE: begin
        // mem_rdata is valid in this cycle for a read issued last cycle
        if (owner_q == c_OWN_HOST) begin
          host_ack_d = 1'b1;
          if (!we_q) host_rdata_d = mem_rdata_i;
        end else begin
          cpu_ack_d = 1'b1;
          if (!we_q) cpu_rdata_d = mem_rdata_i;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= c_OWN_CPU;
      last_owner_q <= c_OWN_HOST;
      we_q         <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      host_gnt_q   <= 1'b0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cpu_gnt_q    <= cpu_gnt_d;
      host_gnt_q   <= host_gnt_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_gnt_o    = cpu_gnt_q;
  assign host_gnt_o   = host_gnt_q;
  assign cpu_ack_o    = cpu_ack_q;
  assign host_ack_o   = host_ack_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign host_rdata_o = host_rdata_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = busy_q;

endmodule

`default_nettype wire
